// File: rtl/encoder_pulse_multi_if.sv
// Input handshake bundle for encoder_pulse_multi: one value vector per window.
interface encoder_pulse_multi_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] in_values;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_values, output in_valid, input  in_ready);
  modport slave  (input  in_values, input  in_valid, output in_ready);
endinterface

// File: rtl/encoder_pulse_multi.sv
// Multi-channel time-to-spike encoder: each accepted vector opens a window of
// MAX_VALUE+1 cycles; channel i fires once, MAX_VALUE - value cycles into it.
module encoder_pulse_multi #(
  parameter int unsigned NUM_CHANNELS     = 4,
  parameter int unsigned MAX_VALUE        = 8,
  parameter bit          ZERO_NO_SPIKE    = 1'b0,
  parameter bit          SPIKE_ACTIVE_LOW = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  encoder_pulse_multi_if.slave    in_if,
  input  logic                    flush,
  output logic [NUM_CHANNELS-1:0] spike_out,
  output logic                    busy,
  output logic                    window_done
);

  localparam int unsigned VW = $clog2(MAX_VALUE + 1);
  localparam logic [VW-1:0] T_LAST = VW'(MAX_VALUE);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                           state_q, state_d;
  logic [VW-1:0]                    t_q, t_d;
  logic [NUM_CHANNELS-1:0][VW-1:0]  vals_q, vals_d;
  logic                             window_end_c;
  logic                             in_ready_c;
  logic                             accept_c;
  logic                             live_c;

  assign in_if.in_ready = in_ready_c;

  // Next-state: flush beats accept beats window end; accepted vectors are clamped on entry.
  always_comb begin
    logic [VW-1:0] raw;
    state_d      = state_q;
    t_d          = t_q;
    vals_d       = vals_q;
    raw          = '0;
    window_end_c = (state_q == RUN) && (t_q == T_LAST);
    in_ready_c   = !reset && !flush && ((state_q == IDLE) || window_end_c);
    accept_c     = in_if.in_valid && in_ready_c;
    if (flush) begin
      state_d = IDLE;
      t_d     = '0;
    end else if (accept_c) begin
      state_d = RUN;
      t_d     = '0;
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        raw       = in_if.in_values[i*VW +: VW];
        vals_d[i] = (raw > T_LAST) ? T_LAST : raw;
      end
    end else if (state_q == RUN) begin
      if (window_end_c) begin
        state_d = IDLE;
        t_d     = '0;
      end else begin
        t_d = t_q + VW'(1);
      end
    end
  end

  // State, window counter and latched values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      vals_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      vals_q  <= vals_d;
    end
  end

  // Spike decode straight from registered t/values; flush and reset force idle lines.
  always_comb begin
    live_c      = (state_q == RUN) && !reset;
    busy        = live_c;
    window_done = live_c && !flush && (t_q == T_LAST);
    spike_out   = '0;
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      spike_out[i] = (live_c && !flush && (t_q == (T_LAST - vals_q[i]))
                      && !(ZERO_NO_SPIKE && (vals_q[i] == '0))) ^ SPIKE_ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_encoder_pulse_multi.sv
// Randomized bench for encoder_pulse_multi: two instances (default and
// zero-suppress/active-high) share one stimulus stream and one window model.
module tb_encoder_pulse_multi;

  localparam int unsigned NCH  = 4;
  localparam int unsigned MAXV = 8;
  localparam int unsigned VW   = 4;
  localparam int unsigned DW   = NCH * VW;

  logic          clock = 1'b0;
  logic          tb_reset = 1'b1;
  logic          tb_flush = 1'b0;
  logic          tb_valid = 1'b0;
  logic [DW-1:0] tb_values = '0;

  logic [NCH-1:0] spike_a, spike_b;
  logic           busy_a, busy_b, done_a, done_b;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;

  // Window model: a window is just its accept cycle plus the clamped values.
  bit            m_active = 1'b0;
  int            m_start  = 0;
  int            m_vals [NCH];

  // Producer: a pending vector is held on the bus until it is taken.
  bit            pend = 1'b0;
  logic [DW-1:0] pend_vals = '0;

  always #5 clock = ~clock;

  encoder_pulse_multi_if #(.DATA_W(DW)) if_a ();
  encoder_pulse_multi_if #(.DATA_W(DW)) if_b ();

  assign if_a.in_values = tb_values;
  assign if_a.in_valid  = tb_valid;
  assign if_b.in_values = tb_values;
  assign if_b.in_valid  = tb_valid;

  encoder_pulse_multi #(
    .NUM_CHANNELS(NCH), .MAX_VALUE(MAXV), .ZERO_NO_SPIKE(1'b0), .SPIKE_ACTIVE_LOW(1'b1)
  ) dut_a (
    .clock(clock), .reset(tb_reset), .in_if(if_a.slave), .flush(tb_flush),
    .spike_out(spike_a), .busy(busy_a), .window_done(done_a)
  );

  encoder_pulse_multi #(
    .NUM_CHANNELS(NCH), .MAX_VALUE(MAXV), .ZERO_NO_SPIKE(1'b1), .SPIKE_ACTIVE_LOW(1'b0)
  ) dut_b (
    .clock(clock), .reset(tb_reset), .in_if(if_b.slave), .flush(tb_flush),
    .spike_out(spike_b), .busy(busy_b), .window_done(done_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [NCH-1:0] exp_spikes(input bit zns, input bit act_low, input int elapsed);
    logic [NCH-1:0] r;
    for (int i = 0; i < int'(NCH); i++) begin
      r[i] = (m_active && !tb_flush && !tb_reset && (elapsed == int'(MAXV) - m_vals[i])
              && !(zns && m_vals[i] == 0)) ^ act_low;
    end
    return r;
  endfunction

  // One clock cycle: present inputs, check at the falling edge, advance the model.
  task automatic step();
    int  elapsed;
    bit  exp_ready, exp_done;
    tb_valid  = pend;
    tb_values = pend ? pend_vals : DW'($urandom);
    @(negedge clock);
    elapsed   = cyc - m_start - 1;
    exp_done  = m_active && !tb_reset && !tb_flush && (elapsed == int'(MAXV));
    exp_ready = !tb_reset && !tb_flush && (!m_active || elapsed == int'(MAXV));
    check_val("busy_a",  32'(busy_a),      32'(m_active && !tb_reset));
    check_val("done_a",  32'(done_a),      32'(exp_done));
    check_val("ready_a", 32'(if_a.in_ready), 32'(exp_ready));
    check_val("spike_a", 32'(spike_a),     32'(exp_spikes(1'b0, 1'b1, elapsed)));
    check_val("spike_b", 32'(spike_b),     32'(exp_spikes(1'b1, 1'b0, elapsed)));
    check_val("done_b",  32'(done_b),      32'(exp_done));
    if (tb_reset || tb_flush) begin
      m_active = 1'b0;
    end else if (tb_valid && exp_ready) begin
      m_active = 1'b1;
      m_start  = cyc;
      for (int i = 0; i < int'(NCH); i++) begin
        m_vals[i] = int'(tb_values[i*VW +: VW]);
        if (m_vals[i] > int'(MAXV)) m_vals[i] = int'(MAXV);
      end
      pend = 1'b0;
    end else if (m_active && elapsed == int'(MAXV)) begin
      m_active = 1'b0;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic offer(input logic [DW-1:0] v);
    pend      = 1'b1;
    pend_vals = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < int'(NCH); i++) m_vals[i] = 0;
    @(posedge clock);
    #1;
    tb_reset = 1'b1;
    idle(3);
    tb_reset = 1'b0;
    idle(2);

    // Basic window {ch0..3}={8,5,0,3}, then back-to-back {1,1,1,1} offered from cycle 2.
    offer({4'd3, 4'd0, 4'd5, 4'd8});
    idle(2);
    offer({4'd1, 4'd1, 4'd1, 4'd1});
    for (int i = 0; i < 20 && pend; i++) step();
    check_val("b2b_taken", 32'(pend), 32'(0));
    idle(12);

    // Flush at cycle 3 of the basic window.
    offer({4'd3, 4'd0, 4'd5, 4'd8});
    idle(3);
    tb_flush = 1'b1;
    idle(1);
    tb_flush = 1'b0;
    idle(4);

    // Clamp: ch0 = 15 and a mix of out-of-range values.
    offer({4'd9, 4'd0, 4'd12, 4'd15});
    idle(12);

    // Reset mid-window at cycle 5.
    offer({4'd3, 4'd0, 4'd5, 4'd8});
    idle(5);
    tb_reset = 1'b1;
    idle(1);
    tb_reset = 1'b0;
    idle(4);

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      if (!pend && ($urandom % 2 == 0)) offer(DW'($urandom));
      tb_flush = ($urandom % 40) == 0;
      tb_reset = ($urandom % 300) == 0;
      step();
    end
    tb_flush = 1'b0;
    tb_reset = 1'b0;
    pend     = 1'b0;
    idle(12);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
